freq_gate_ctrl: RTL and testbench

FREQ_GATE_CTRL -- requirements
Module: freq_gate_ctrl

---
 rtl/freq_pkg.sv | 16 +
 rtl/gate_timer.sv | 38 +++
 rtl/freq_gate_ctrl.sv | 130 +++++++++++++
 tb/tb_freq_gate_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// Shared definitions for the frequency gate controller.
//   CNT_W_DEF : default width of the count / frequency words
//   state_t   : measurement FSM state encoding (3 bits)
package freq_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_GATE   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_LATCH  = 3'd4
  } state_t;

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter used to time the gate-open and settle windows.
// Ports:
//   clock    : system clock, rising edge
//   reset    : synchronous active-high reset (count -> 0)
//   load     : load load_val into the counter (priority over en)
//   load_val : value to load
//   en       : decrement enable; the counter stops at zero, never wraps
//   done     : high while the current cycle is the last one of the window
//   count    : current counter value
module gate_timer
  import freq_pkg::*;
#(
  parameter int TIMER_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               en,
  output logic               done,
  output logic [TIMER_W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // A window loaded with N ends on the cycle the counter shows 1; zero is
  // treated the same so a stray empty window cannot stall the FSM.
  assign done = (count <= TIMER_W'(1));

endmodule

// File: rtl/freq_gate_ctrl.sv
// Frequency measurement controller: opens a gate window of GATE_CYCLES
// clocks for an external edge counter, waits SETTLE_CYCLES, then latches
// the count as the measured frequency. Runs single-shot or back-to-back.
// Ports:
//   clock         : system clock, rising edge
//   reset         : synchronous active-high reset
//   start         : single-shot request, only honoured in IDLE
//   continuous    : repeat measurements while high
//   count_in      : running edge count from the counter datapath
//   gate          : counter enable window (registered)
//   counter_clear : one-cycle counter clear strobe (registered)
//   freq          : last latched count, held between measurements
//   freq_valid    : one-cycle strobe, freq was just updated
//   overflow      : counter wrapped during the last measurement
//   busy          : high in every state except IDLE
module freq_gate_ctrl
  import freq_pkg::*;
#(
  parameter int GATE_CYCLES   = 2500,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic [CNT_W-1:0] count_in,
  output logic             gate,
  output logic             counter_clear,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             overflow,
  output logic             busy
);

  // The timer also has to hold SETTLE_CYCLES, which may exceed a tiny gate.
  localparam int TMAX    = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TIMER_W = $clog2(TMAX + 1);

  state_t state, next_state;

  logic               timer_load;
  logic               timer_en;
  logic               timer_done;
  logic [TIMER_W-1:0] timer_val;
  logic [TIMER_W-1:0] timer_count;

  logic               gate_d;
  logic               clear_d;
  logic               wrap_flag;
  logic [CNT_W-1:0]   count_in_p1;

  gate_timer #(
    .TIMER_W (TIMER_W)
  ) u_gate_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .en       (timer_en),
    .done     (timer_done),
    .count    (timer_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start || continuous) next_state = ST_CLEAR;
      ST_CLEAR:  next_state = ST_GATE;
      ST_GATE:   if (timer_done) next_state = ST_SETTLE;
      ST_SETTLE: if (timer_done) next_state = ST_LATCH;
      ST_LATCH:  next_state = continuous ? ST_CLEAR : ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // gate/counter_clear are decoded from next_state and then registered, so
  // they line up with the state they belong to and are glitch-free.
  always_comb begin
    gate_d     = (next_state == ST_GATE);
    clear_d    = (next_state == ST_CLEAR);
    busy       = (state != ST_IDLE);
    timer_load = (state == ST_CLEAR) || ((state == ST_GATE) && timer_done);
    timer_val  = (state == ST_CLEAR) ? TIMER_W'(GATE_CYCLES) : TIMER_W'(SETTLE_CYCLES);
    timer_en   = (state == ST_GATE) || (state == ST_SETTLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      gate          <= 1'b0;
      counter_clear <= 1'b0;
      freq_valid    <= 1'b0;
      overflow      <= 1'b0;
      freq          <= '0;
      wrap_flag     <= 1'b0;
    end else begin
      gate          <= gate_d;
      counter_clear <= clear_d;
      freq_valid    <= (state == ST_LATCH);
      if (state == ST_LATCH) begin
        freq     <= count_in;
        overflow <= wrap_flag;
      end
      if (state == ST_CLEAR) begin
        wrap_flag <= 1'b0;
      end else if (((state == ST_GATE) || (state == ST_SETTLE)) && (count_in < count_in_p1)) begin
        wrap_flag <= 1'b1;
      end
    end
  end

  // The counter still shows the old total during CLEAR, so the history is
  // zeroed there to avoid a false wrap on the first gate cycle.
  always_ff @(posedge clock) begin
    if (state == ST_CLEAR) begin
      count_in_p1 <= '0;
    end else begin
      count_in_p1 <= count_in;
    end
  end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
module tb_freq_gate_ctrl;

  localparam int G = 10;
  localparam int S = 2;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic         continuous;
  logic [W-1:0] count_in;
  logic         gate;
  logic         counter_clear;
  logic [W-1:0] freq;
  logic         freq_valid;
  logic         overflow;
  logic         busy;

  freq_gate_ctrl #(
    .GATE_CYCLES   (G),
    .SETTLE_CYCLES (S),
    .CNT_W         (W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .continuous    (continuous),
    .count_in      (count_in),
    .gate          (gate),
    .counter_clear (counter_clear),
    .freq          (freq),
    .freq_valid    (freq_valid),
    .overflow      (overflow),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  // Edge counter model: counts the first 7 gate cycles of each window.
  logic wrap_mode = 1'b0;
  int   gidx = 0;
  initial count_in = '0;
  always @(posedge clock) begin
    if (counter_clear) begin
      count_in <= wrap_mode ? 32'hFFFF_FFFC : 32'h0;
      gidx     <= 0;
    end else if (gate) begin
      if (gidx < 7) count_in <= count_in + 1;
      gidx <= gidx + 1;
    end
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int base  = 0;
  int gate_n, clear_n, valid_n, overlap_n;
  int first_gate, last_gate, first_clear;
  int valid_at[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    gate_n = 0; clear_n = 0; valid_n = 0; overlap_n = 0;
    first_gate = -1; last_gate = -1; first_clear = -1;
    valid_at.delete();
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic sample();
    if (gate) begin
      gate_n++;
      if (first_gate < 0) first_gate = cyc - base;
      last_gate = cyc - base;
    end
    if (counter_clear) begin
      clear_n++;
      if (first_clear < 0) first_clear = cyc - base;
    end
    if (gate && counter_clear) overlap_n++;
    if (freq_valid) begin
      valid_n++;
      valid_at.push_back(cyc - base);
    end
  endtask

  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      sample();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; continuous = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_gate",  gate, 0);
    chk("rst_clear", counter_clear, 0);
    chk("rst_freq",  freq, 0);
    chk("rst_valid", freq_valid, 0);
    chk("rst_ovf",   overflow, 0);
    chk("rst_busy",  busy, 0);

    // single shot
    clr_stats();
    start = 1'b1; base = cyc;
    watch(1);
    start = 1'b0;
    chk("ss_clear_now", counter_clear, 1);
    chk("ss_busy_now",  busy, 1);
    watch(19);
    chk("ss_first_clear", first_clear, 1);
    chk("ss_first_gate",  first_gate, 2);
    chk("ss_last_gate",   last_gate, 11);
    chk("ss_gate_n",      gate_n, 10);
    chk("ss_valid_n",     valid_n, 1);
    chk("ss_valid_at",    (valid_at.size() > 0) ? valid_at[0] : -1, 15);
    chk("ss_overlap",     overlap_n, 0);
    chk("ss_freq",        freq, 7);
    chk("ss_ovf",         overflow, 0);
    chk("ss_busy_end",    busy, 0);

    // continuous for three windows, dropped inside the third gate
    clr_stats();
    continuous = 1'b1; base = cyc;
    watch(32);
    continuous = 1'b0;
    watch(20);
    chk("ct_valid_n", valid_n, 3);
    chk("ct_valid0",  (valid_at.size() > 0) ? valid_at[0] : -1, 15);
    chk("ct_valid1",  (valid_at.size() > 1) ? valid_at[1] : -1, 29);
    chk("ct_valid2",  (valid_at.size() > 2) ? valid_at[2] : -1, 43);
    chk("ct_clear_n", clear_n, 3);
    chk("ct_gate_n",  gate_n, 30);
    chk("ct_overlap", overlap_n, 0);
    chk("ct_freq",    freq, 7);
    chk("ct_busy",    busy, 0);

    // continuous dropped mid-gate, start pulses while busy are ignored
    clr_stats();
    continuous = 1'b1; base = cyc;
    watch(5);
    continuous = 1'b0; start = 1'b1;
    watch(1);
    start = 1'b0;
    watch(3);
    start = 1'b1;
    watch(1);
    start = 1'b0;
    watch(15);
    chk("dr_valid_n", valid_n, 1);
    chk("dr_valid_at", (valid_at.size() > 0) ? valid_at[0] : -1, 15);
    chk("dr_clear_n", clear_n, 1);
    chk("dr_gate_n",  gate_n, 10);
    chk("dr_busy",    busy, 0);

    // counter wraps inside the window
    clr_stats();
    wrap_mode = 1'b1;
    start = 1'b1; base = cyc;
    watch(1);
    start = 1'b0;
    watch(19);
    chk("wr_valid_n", valid_n, 1);
    chk("wr_freq",    freq, 3);
    chk("wr_ovf",     overflow, 1);

    // clean measurement after the wrap
    clr_stats();
    wrap_mode = 1'b0;
    start = 1'b1; base = cyc;
    watch(1);
    start = 1'b0;
    watch(19);
    chk("cl_valid_n", valid_n, 1);
    chk("cl_freq",    freq, 7);
    chk("cl_ovf",     overflow, 0);

    // reset during the 5th gate cycle
    reset = 1'b1; tick(); reset = 1'b0;
    clr_stats();
    start = 1'b1; base = cyc;
    watch(1);
    start = 1'b0;
    watch(5);
    chk("ab_gate_before", gate, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ab_gate",  gate, 0);
    chk("ab_busy",  busy, 0);
    chk("ab_state", dut.state, 0);
    clr_stats();
    watch(20);
    chk("ab_valid_n", valid_n, 0);
    chk("ab_gate_n",  gate_n, 0);
    chk("ab_freq",    freq, 0);

    // start and reset together
    start = 1'b1; reset = 1'b1;
    tick();
    chk("sr_busy",  busy, 0);
    chk("sr_clear", counter_clear, 0);
    start = 1'b0; reset = 1'b0;
    tick();
    chk("sr_busy2",  busy, 0);
    chk("sr_clear2", counter_clear, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
